// File: rtl/button_debounce_multi.sv
// Multi-channel button debouncer with press/release pulses and hold-to-auto-repeat.
//
// Each channel runs its own 2-FF synchroniser, a tick-based stability filter and
// an auto-repeat counter. All filtering advances only on the shared i_ena strobe.
//
// Ports:
//   i_clk      system clock, all logic on the rising edge
//   i_rst      synchronous reset, active-high
//   i_ena      sample strobe, high for one i_clk cycle per tick
//   i_btn      raw asynchronous button pins (N_CH)
//   o_q        debounced level, 1 = pressed
//   o_press    1-cycle pulse when o_q goes 0->1
//   o_release  1-cycle pulse when o_q goes 1->0
//   o_repeat   1-cycle auto-repeat pulse while held
module button_debounce_multi #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned STABLE_TICKS = 4,
    parameter int unsigned HOLD_TICKS   = 250,
    parameter int unsigned REPEAT_TICKS = 50,
    parameter bit          ACTIVE_LOW   = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ena,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_q,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_repeat
);

    localparam int unsigned CW = (STABLE_TICKS < 1) ? 1 : $clog2(STABLE_TICKS + 1);
    localparam int unsigned RW = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
    localparam bit          REPEAT_EN = (REPEAT_TICKS != 0);

    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_TICKS - 1);
    // Reloading here puts the next pulse exactly REPEAT_TICKS ticks later.
    localparam logic [RW-1:0] RPT_RELOAD = RW'(HOLD_TICKS - REPEAT_TICKS);

    // Pin level that corresponds to "not pressed".
    localparam logic [N_CH-1:0] PIN_IDLE = {N_CH{ACTIVE_LOW}};

    if (STABLE_TICKS == 0) begin : g_bad_stable
        $error("button_debounce_multi: STABLE_TICKS must be >= 1");
    end
    if (REPEAT_TICKS > HOLD_TICKS) begin : g_bad_repeat
        $error("button_debounce_multi: REPEAT_TICKS must not exceed HOLD_TICKS");
    end

    logic [N_CH-1:0]         sync1_q, sync2_q;
    logic [N_CH-1:0]         s;
    logic [N_CH-1:0]         q_q, q_d;
    logic [N_CH-1:0]         press_q, press_d;
    logic [N_CH-1:0]         release_q, release_d;
    logic [N_CH-1:0]         repeat_q, repeat_d;
    logic [N_CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0][RW-1:0] rpt_q, rpt_d;

    // Synchronised level in "1 = pressed" polarity.
    assign s = sync2_q ^ PIN_IDLE;

    always_comb begin
        q_d       = q_q;
        cnt_d     = cnt_q;
        rpt_d     = rpt_q;
        press_d   = '0;
        release_d = '0;
        repeat_d  = '0;

        for (int k = 0; k < int'(N_CH); k++) begin
            // Stability filter: STABLE_TICKS consecutive differing samples, no partial credit.
            if (i_ena) begin
                if (s[k] == q_q[k]) begin
                    cnt_d[k] = '0;
                end else if (cnt_q[k] == CNT_LAST) begin
                    q_d[k]       = s[k];
                    cnt_d[k]     = '0;
                    press_d[k]   = s[k];
                    release_d[k] = ~s[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end

            // Auto-repeat counts only ticks spent with o_q already high; the release
            // edge clears it so a repeat can never coincide with a release.
            if (!REPEAT_EN || !q_q[k] || release_d[k]) begin
                rpt_d[k] = '0;
            end else if (i_ena) begin
                if (rpt_q[k] == HOLD_LAST) begin
                    repeat_d[k] = 1'b1;
                    rpt_d[k]    = RPT_RELOAD;
                end else begin
                    rpt_d[k] = rpt_q[k] + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q   <= PIN_IDLE;
            sync2_q   <= PIN_IDLE;
            q_q       <= '0;
            cnt_q     <= '0;
            rpt_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
        end else begin
            sync1_q   <= i_btn;
            sync2_q   <= sync1_q;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            rpt_q     <= rpt_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    assign o_q       = q_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_repeat  = repeat_q;

endmodule

// File: tb/tb_button_debounce_multi.sv
module tb_button_debounce_multi;

    localparam int N_CH   = 4;
    localparam int ST     = 4;
    localparam int HOLD   = 20;
    localparam int REP    = 5;
    localparam int ENA_PD = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ena = 1'b0;
    logic [N_CH-1:0] btn = '0;

    logic [N_CH-1:0] q_h, press_h, rel_h, rep_h;
    logic [N_CH-1:0] q_l, press_l, rel_l, rep_l;

    int n_checks = 0;
    int n_errors = 0;
    int rep2_cnt = 0;
    int press1_cnt = 0;

    always #5 clk = ~clk;

    button_debounce_multi #(
        .N_CH(N_CH), .STABLE_TICKS(ST), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP), .ACTIVE_LOW(1'b0)
    ) u_dut_hi (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_btn(btn),
        .o_q(q_h), .o_press(press_h), .o_release(rel_h), .o_repeat(rep_h)
    );

    button_debounce_multi #(
        .N_CH(N_CH), .STABLE_TICKS(ST), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP), .ACTIVE_LOW(1'b1)
    ) u_dut_lo (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_btn(~btn),
        .o_q(q_l), .o_press(press_l), .o_release(rel_l), .o_repeat(rep_l)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Strobe: one cycle high every ENA_PD clocks, driven away from the active edge.
    initial begin
        int ena_cnt = 0;
        forever begin
            @(negedge clk);
            ena_cnt++;
            ena = (ena_cnt % ENA_PD == 0);
        end
    end

    // Reference model, logical (1 = pressed) polarity.
    bit p1 [N_CH];
    bit p2 [N_CH];
    bit mq [N_CH];
    int held [N_CH];
    bit hist [N_CH][$];
    logic [N_CH-1:0] e_q, e_press, e_rel, e_rep;

    task automatic model_step();
        bit s, was, all_diff;
        for (int k = 0; k < N_CH; k++) begin
            e_press[k] = 1'b0;
            e_rel[k]   = 1'b0;
            e_rep[k]   = 1'b0;
            if (rst) begin
                p1[k] = 1'b0;
                p2[k] = 1'b0;
                mq[k] = 1'b0;
                held[k] = 0;
                hist[k].delete();
            end else begin
                s   = p2[k];
                was = mq[k];
                if (ena) begin
                    // Accept when the last ST samples since the previous change all differ.
                    hist[k].push_back(s);
                    if (hist[k].size() > ST) void'(hist[k].pop_front());
                    all_diff = (hist[k].size() == ST);
                    foreach (hist[k][i]) if (hist[k][i] == mq[k]) all_diff = 1'b0;
                    if (all_diff) begin
                        mq[k] = s;
                        e_press[k] = s;
                        e_rel[k] = ~s;
                        hist[k].delete();
                    end
                    if (was && !e_rel[k]) begin
                        held[k]++;
                        if (held[k] >= HOLD && (held[k] - HOLD) % REP == 0) e_rep[k] = 1'b1;
                    end
                end
                if (!was || e_rel[k]) held[k] = 0;
                p2[k] = p1[k];
                p1[k] = btn[k];
            end
            e_q[k] = mq[k];
        end
    endtask

    // Cycle-by-cycle scoreboard for both polarities.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check_eq("q_hi", q_h, e_q);
            check_eq("press_hi", press_h, e_press);
            check_eq("release_hi", rel_h, e_rel);
            check_eq("repeat_hi", rep_h, e_rep);
            check_eq("q_lo", q_l, e_q);
            check_eq("press_lo", press_l, e_press);
            check_eq("release_lo", rel_l, e_rel);
            check_eq("repeat_lo", rep_l, e_rep);
            if (rep_h[2]) rep2_cnt++;
            if (press_h[1]) press1_cnt++;
        end
    end

    // kind 0 = press, 1 = release; returns the pulse vector or 0 on timeout.
    task automatic wait_ev(input int kind, input int budget, output logic [N_CH-1:0] v);
        v = '0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            v = (kind == 0) ? press_h : rel_h;
            if (v != '0) break;
        end
    endtask

    initial begin
        logic [N_CH-1:0] v;
        int ticks;

        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("reset_q", q_h, 4'b0000);
        check_eq("reset_pulses", press_h | rel_h | rep_h, 4'b0000);

        // 1: clean press on ch0
        @(negedge clk);
        btn[0] = 1'b1;
        wait_ev(0, 200, v);
        check_eq("t1_press", v, 4'b0001);

        // 2: bounce on ch1 (toggle every 15 clk, ends high)
        press1_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            btn[1] = ~btn[1];
            repeat (14) @(negedge clk);
        end
        wait_ev(0, 200, v);
        check_eq("t2_press", v, 4'b0010);
        repeat (100) @(negedge clk);
        check_eq("t2_press_count", press1_cnt, 1);

        // 3: release ch0
        @(negedge clk);
        btn[0] = 1'b0;
        wait_ev(1, 200, v);
        check_eq("t3_release", v, 4'b0001);

        // 4: hold ch2; release so o_q drops at tick 59 after press -> repeats at 20..55
        @(negedge clk);
        btn[2] = 1'b1;
        wait_ev(0, 200, v);
        check_eq("t4_press", v, 4'b0100);
        rep2_cnt = 0;
        ticks = 0;
        for (int i = 0; i < 2000 && ticks < 55; i++) begin
            @(posedge clk);
            if (ena) ticks++;
        end
        @(negedge clk);
        btn[2] = 1'b0;
        wait_ev(1, 200, v);
        check_eq("t4_release", v, 4'b0100);
        check_eq("t4_repeat_count", rep2_cnt, 8);
        repeat (300) @(negedge clk);
        check_eq("t4_no_repeat_after", rep2_cnt, 8);

        // 5: simultaneous press on ch0 and ch3
        @(negedge clk);
        btn[0] = 1'b1;
        btn[3] = 1'b1;
        wait_ev(0, 200, v);
        check_eq("t5_press", v, 4'b1001);

        // 6: reset during ch2 repeat; every held channel re-presses afterwards
        @(negedge clk);
        btn[2] = 1'b1;
        wait_ev(0, 200, v);
        check_eq("t6_press", v, 4'b0100);
        repeat (250 + $urandom_range(0, 30)) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6_rst_q", q_h, 4'b0000);
        check_eq("t6_rst_pulses", press_h | rel_h | rep_h, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        wait_ev(0, 200, v);
        check_eq("t6_repress", v, 4'b1111);
        repeat (300) @(negedge clk);

        // Random phase: toggles with random dwell, occasional reset.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) rst = 1'b1;
            else rst = 1'b0;
            btn[$urandom_range(0, N_CH - 1)] ^= 1'b1;
            repeat ($urandom_range(1, 80)) @(negedge clk);
            rst = 1'b0;
        end
        @(negedge clk);
        btn = '0;
        repeat (200) @(negedge clk);
        check_eq("final_q", q_h, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
